sdram_port_arbiter: RTL

- Shares the single SDRAM bridge master port between the fractal-calc pixel writer and the VGA bitmap reader.
- Resolves simultaneous requests and drives the bridge read/write strobes, holding them until the bridge acknowledges.
- Returns completion pulses and read data to each requester.
- Sits at top level between fractal_calc, the VGA interface and jsv_sdram, replacing direct strobe wiring.

---
 rtl/sdram_port_arbiter_pkg.sv | 24 ++
 rtl/sdram_port_arbiter_if.sv | 40 ++++
 rtl/sdram_port_arbiter_arb_priority_sel.sv | 18 +
 rtl/sdram_port_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM bridge port arbiter.
// The arbiter's optional ack watchdog is enabled with the ARB_WATCHDOG_EN macro.
package jsv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } arb_state_t;

  localparam int SDRAM_ADDR_W     = 23;
  localparam int PIXEL_W          = 8;
  localparam int DEF_MAX_WR_BURST = 4;
  localparam int DEF_TIMEOUT      = 1024;

  // Consecutive-write count after a write grant: it only counts while a read waits.
  function automatic logic [3:0] burst_next(input logic [3:0] cnt, input logic rd_pending,
                                            input int max_burst);
    if (!rd_pending)                   return 4'd0;
    else if (cnt == 4'(max_burst))     return cnt;
    else                               return cnt + 4'd1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester and bridge signals of the SDRAM port arbiter.
// master = the arbiter itself, slave = requesters plus bridge.
interface sdram_port_arbiter_if
  import jsv_mem_pkg::*;
#(
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int DATA_W = PIXEL_W
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              rd_req;
  logic              rd_urgent;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] bridge_address;
  logic              bridge_read;
  logic              bridge_write;
  logic [DATA_W-1:0] bridge_write_data;
  logic              bridge_acknowledge;
  logic [DATA_W-1:0] bridge_read_data;
  logic              busy;
  logic              arb_error;

  modport master (
    input  wr_req, wr_addr, wr_data, rd_req, rd_urgent, rd_addr,
           bridge_acknowledge, bridge_read_data,
    output wr_done, rd_data, rd_valid, bridge_address, bridge_read, bridge_write,
           bridge_write_data, busy, arb_error
  );

  modport slave (
    output wr_req, wr_addr, wr_data, rd_req, rd_urgent, rd_addr,
           bridge_acknowledge, bridge_read_data,
    input  wr_done, rd_data, rd_valid, bridge_address, bridge_read, bridge_write,
           bridge_write_data, busy, arb_error
  );
endinterface

// File: rtl/sdram_port_arbiter_arb_priority_sel.sv
// Next-grant selection for the SDRAM port arbiter; only meaningful while IDLE.
module arb_priority_sel (
  input  logic rd_req,
  input  logic rd_urgent,
  input  logic wr_req,
  input  logic burst_limit_hit,
  output logic grant_rd,
  output logic grant_wr
);
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_req && rd_urgent)            grant_rd = 1'b1;
    else if (rd_req && burst_limit_hit) grant_rd = 1'b1;
    else if (wr_req)                    grant_wr = 1'b1;
    else if (rd_req)                    grant_rd = 1'b1;
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM bridge port between the pixel writer and the VGA reader.
// Optional ack watchdog: define ARB_WATCHDOG_EN.
module sdram_port_arbiter
  import jsv_mem_pkg::*;
#(
  parameter int ADDR_W       = SDRAM_ADDR_W,
  parameter int DATA_W       = PIXEL_W,
  parameter int MAX_WR_BURST = DEF_MAX_WR_BURST,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input logic              CLK,
  input logic              RESET_N,
  sdram_port_arbiter_if.master bus
);

  if (MAX_WR_BURST < 1 || MAX_WR_BURST > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("sdram_port_arbiter: MAX_WR_BURST must be 1..15 and TIMEOUT >= 1");
  end

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_done_q, wr_done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              grant_rd, grant_wr;
  logic              wd_expired;

  arb_priority_sel u_sel (
    .rd_req          (bus.rd_req),
    .rd_urgent       (bus.rd_urgent),
    .wr_req          (bus.wr_req),
    .burst_limit_hit (burst_cnt_q == 4'(MAX_WR_BURST)),
    .grant_rd        (grant_rd),
    .grant_wr        (grant_wr)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    wr_done_d   = 1'b0;
    rd_valid_d  = 1'b0;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        // Acks seen here belong to nothing and are dropped.
        if (grant_rd) begin
          state_d     = RD;
          addr_d      = bus.rd_addr;
          burst_cnt_d = 4'd0;
        end else if (grant_wr) begin
          state_d     = WR;
          addr_d      = bus.wr_addr;
          wdata_d     = bus.wr_data;
          burst_cnt_d = burst_next(burst_cnt_q, bus.rd_req, MAX_WR_BURST);
        end
      end
      WR: begin
        if (bus.bridge_acknowledge) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end else if (wd_expired) begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (bus.bridge_acknowledge) begin
          state_d    = IDLE;
          rd_valid_d = 1'b1;
          rd_data_d  = bus.bridge_read_data;
        end else if (wd_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      wr_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      wr_done_q   <= wr_done_d;
      rd_valid_q  <= rd_valid_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            arb_error_q, arb_error_d;

  // Counter sits at zero in IDLE, so it restarts on every grant.
  assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT - 1)) && !bus.bridge_acknowledge;

  always_comb begin
    wd_cnt_d    = (state_q == IDLE) ? '0 : wd_cnt_q + 1'b1;
    arb_error_d = arb_error_q | (state_q != IDLE && wd_expired);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_cnt_q    <= '0;
      arb_error_q <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      arb_error_q <= arb_error_d;
    end
  end

  assign bus.arb_error = arb_error_q;
`else
  assign wd_expired    = 1'b0;
  assign bus.arb_error = 1'b0;
`endif

  assign bus.bridge_read       = (state_q == RD);
  assign bus.bridge_write      = (state_q == WR);
  assign bus.busy              = (state_q != IDLE);
  assign bus.bridge_address    = addr_q;
  assign bus.bridge_write_data = wdata_q;
  assign bus.wr_done           = wr_done_q;
  assign bus.rd_valid          = rd_valid_q;
  assign bus.rd_data           = rd_data_q;

endmodule
